vga_plot_sink: RTL and testbench
================================

# vga_plot_sink

Receiving end of the pixel-plot interface driven by the shape drawers (circle, reuleaux, fill). Captures plot strobes into an internal 160x120x3 frame store, supports a full-screen clear, and replays the stored frame in raster order over a valid/ready pixel stream. Used by the lab testbench and the on-board frame dumper to check drawer output pixel by pixel.

## Interface
- WIDTH, 160, frame width in pixels
- HEIGHT, 120, frame height in pixels
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- vga_x  in  8  plot x coordinate
- vga_y  in  7  plot y coordinate
- vga_colour  in  3  plot colour
- vga_plot  in  1  write strobe, one pixel per cycle
- clear_start  in  1  request full-frame fill with clear_colour
- clear_colour  in  3  fill colour, sampled when clear_start accepted
- clear_done  out  1  one-cycle pulse, clear finished
- scan_start  in  1  request raster readout
- pix_valid  out  1  pix_x/pix_y/pix_colour hold a frame pixel
- pix_ready  in  1  consumer accepts pixel when pix_valid & pix_ready
- pix_x  out  8  readout x
- pix_y  out  7  readout y
- pix_colour  out  3  readout colour
- scan_done  out  1  one-cycle pulse, last pixel accepted
- busy  out  1  state is not IDLE
- plot_count  out  16  accepted plot writes since last clear, saturating at 65535

## Operation
- States: IDLE, CLEAR, FETCH, SHOW.
- Address = vga_y*WIDTH + vga_x, 15 bits unsigned; WIDTH*HEIGHT = 19200 entries.
- Plot write: accepted when vga_plot=1, vga_x<WIDTH, vga_y<HEIGHT, state in {IDLE, FETCH, SHOW}; writes vga_colour, plot_count += 1 (saturating). Out-of-range coordinates or state CLEAR: write dropped, count unchanged.
- IDLE: clear_start=1 -> CLEAR, latch clear_colour, address counter=0, plot_count=0. Else scan_start=1 -> FETCH, pix_x=pix_y=0. Both high: clear wins, scan_start ignored. Starts ignored outside IDLE.
- CLEAR: write latched colour to counter address each cycle, counter+1; at address 19199 -> IDLE, clear_done=1 next cycle.
- FETCH: issue synchronous read of (pix_x,pix_y) -> SHOW.
- SHOW: pix_valid=1, pix_colour = read data, held stable until handshake. On handshake: if (pix_x,pix_y)=(WIDTH-1,HEIGHT-1) -> IDLE, scan_done=1; else advance x, wrap x to 0 and y+1 at WIDTH-1 -> FETCH.
- Read/write collision: a plot write in the same cycle as the FETCH read to the same address returns old data; pixel presented in SHOW never changes due to later writes.
- Memory contents are not reset; undefined until first clear.

## Timing
- Reset: all outputs 0, state IDLE, plot_count 0, pix_x/pix_y 0. Reset mid-CLEAR or mid-scan: abort, IDLE next cycle, no done pulse, partially cleared memory retained.
- Plot write latency: written on the edge sampling vga_plot; readable by a FETCH in the following cycle.
- Clear: clear_start sampled at edge 0 -> busy=1 after edge 0, 19200 write cycles, clear_done high for exactly one cycle after edge 19200, busy=0 in that same cycle; total 19201 cycles until IDLE.
- Scan: scan_start at edge 0 -> FETCH cycle, pix_valid=1 after edge 1. Throughput one pixel per 2 cycles with pix_ready held high; full frame 38400 cycles; scan_done pulses in the cycle after the final handshake.
- pix_valid deasserts the cycle after each handshake (FETCH bubble); never drops without a handshake.
- plot_count saturates at 65535, no wrap.

## Test plan
- Reset then clear_start with clear_colour=3'b010 -> busy 19200 cycles, clear_done single pulse at cycle 19201, full scan returns 19200 pixels of 3'b010, plot_count=0.
- After clear to 0, plot (0,0)=7, (159,119)=5, (80,60)=3 plus (160,10) and (10,120) -> plot_count=3; scan shows exactly those three nonzero pixels at raster indices 0, 9680, 19199.
- Scan with pix_ready toggling randomly -> pix_x/pix_y/pix_colour stable while pix_valid & !pix_ready, 19200 handshakes, raster order, scan_done once.
- clear_start and scan_start asserted together in IDLE -> CLEAR entered, no pix_valid; plots during CLEAR dropped, plot_count stays 0.
- Plot to (5,0) in the FETCH cycle of pixel (5,0) with new colour 6 over cleared 1 -> presented colour 1; next scan shows 6.
- rst_n low at cycle 5000 of CLEAR -> IDLE next cycle, outputs 0, no clear_done; pixels index <5000 hold clear colour.

Source files
------------

// File: rtl/vga_plot_sink.sv
// ============================================================================
// vga_plot_sink : plot-strobe frame store with full clear and raster readout
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module vga_plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear_start,
    input  logic [2:0]  clear_colour,
    output logic        clear_done,
    input  logic        scan_start,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_x,
    output logic [6:0]  pix_y,
    output logic [2:0]  pix_colour,
    output logic        scan_done,
    output logic        busy,
    output logic [15:0] plot_count
);

    localparam int          NPIX      = WIDTH * HEIGHT;
    localparam int          AW        = $clog2(NPIX);
    localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FETCH = 2'd2,
        SHOW  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]  mem [NPIX];
    logic [14:0] clr_addr;
    logic [2:0]  clr_colour;
    logic [2:0]  rd_data;

    logic [14:0] plot_addr;
    logic [14:0] scan_addr;
    logic        plot_ok;
    logic        handshake;
    logic        last_pix;

    assign plot_addr  = 15'(vga_y) * 15'(WIDTH) + 15'(vga_x);
    assign scan_addr  = 15'(pix_y) * 15'(WIDTH) + 15'(pix_x);
    assign plot_ok    = vga_plot && (vga_x < 8'(WIDTH)) && (vga_y < 7'(HEIGHT))
                        && (state != CLEAR);
    assign handshake  = (state == SHOW) && pix_ready;
    assign last_pix   = (pix_x == 8'(WIDTH - 1)) && (pix_y == 7'(HEIGHT - 1));
    assign pix_colour = rd_data;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pix_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (clear_start)     state_next = CLEAR;
                else if (scan_start) state_next = FETCH;
            end
            CLEAR: begin
                if (clr_addr == LAST_ADDR) state_next = IDLE;
            end
            FETCH: state_next = SHOW;
            SHOW: begin
                pix_valid = 1'b1;
                if (pix_ready) state_next = last_pix ? IDLE : FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    // Writes are held off during reset so an aborted clear stops cleanly.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) mem[clr_addr[AW-1:0]]  <= clr_colour;
            else if (plot_ok)   mem[plot_addr[AW-1:0]] <= vga_colour;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_addr   <= '0;
            clr_colour <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            rd_data    <= '0;
            clear_done <= 1'b0;
            scan_done  <= 1'b0;
            plot_count <= '0;
        end else begin
            clear_done <= (state == CLEAR) && (clr_addr == LAST_ADDR);
            scan_done  <= handshake && last_pix;

            if ((state == IDLE) && clear_start)
                plot_count <= '0;
            else if (plot_ok && (plot_count != 16'hFFFF))
                plot_count <= plot_count + 16'd1;

            case (state)
                IDLE: begin
                    if (clear_start) begin
                        clr_addr   <= '0;
                        clr_colour <= clear_colour;
                    end else if (scan_start) begin
                        pix_x <= '0;
                        pix_y <= '0;
                    end
                end
                CLEAR: clr_addr <= clr_addr + 15'd1;
                // Read-before-write: a same-cycle plot to this address is not seen.
                FETCH: rd_data <= mem[scan_addr[AW-1:0]];
                SHOW: begin
                    if (pix_ready && !last_pix) begin
                        if (pix_x == 8'(WIDTH - 1)) begin
                            pix_x <= '0;
                            pix_y <= pix_y + 7'd1;
                        end else begin
                            pix_x <= pix_x + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_plot_sink.sv
// ============================================================================
// tb_vga_plot_sink : self-checking bench on a reduced 20x12 frame
// Revision 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_vga_plot_sink;

    localparam int W = 20;
    localparam int H = 12;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  vga_x = '0;
    logic [6:0]  vga_y = '0;
    logic [2:0]  vga_colour = '0;
    logic        vga_plot = 1'b0;
    logic        clear_start = 1'b0;
    logic [2:0]  clear_colour = '0;
    logic        clear_done;
    logic        scan_start = 1'b0;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [2:0]  pix_colour;
    logic        scan_done;
    logic        busy;
    logic [15:0] plot_count;

    always #5 clk = ~clk;

    vga_plot_sink #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .scan_start   (scan_start),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_colour   (pix_colour),
        .scan_done    (scan_done),
        .busy         (busy),
        .plot_count   (plot_count)
    );

    int checks = 0;
    int errors = 0;

    // Frame model: colour per raster index, plus "unknown" marks.
    logic [2:0] model_mem [N];
    bit         model_dc  [N];
    int         model_count = 0;
    logic [2:0] exp_mem   [N];
    bit         exp_dc    [N];
    logic [2:0] captured  [N];

    bit scanning   = 1'b0;
    bit rand_ready = 1'b0;
    int scan_idx   = 0;
    int done_pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output stream checker, sampled on the falling edge.
    initial begin : compare
        bit         pv, pr, hs_prev;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        pv = 1'b0; pr = 1'b0; hs_prev = 1'b0;
        px = '0; py = '0; pc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                hs_prev = 1'b0;
            end else if (!scanning) begin
                check("idle_pix_valid", int'(pix_valid), 0);
                check("idle_scan_done", int'(scan_done), 0);
                pv = 1'b0;
                hs_prev = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("hold_valid", int'(pix_valid), 1);
                    check("hold_x", int'(pix_x), int'(px));
                    check("hold_y", int'(pix_y), int'(py));
                    check("hold_colour", int'(pix_colour), int'(pc));
                end
                if (hs_prev && !scan_done)
                    check("fetch_bubble", int'(pix_valid), 0);
                if (scan_done) begin
                    done_pulses++;
                    check("done_after_last", scan_idx, N);
                end
                if (pix_valid) begin
                    if (scan_idx < N) begin
                        check("pix_x", int'(pix_x), scan_idx % W);
                        check("pix_y", int'(pix_y), scan_idx / W);
                        if (!exp_dc[scan_idx])
                            check("pix_colour", int'(pix_colour), int'(exp_mem[scan_idx]));
                        captured[scan_idx] = pix_colour;
                    end else begin
                        check("extra_pixel_index", scan_idx, N - 1);
                    end
                    if (pix_ready) scan_idx++;
                end
                hs_prev = pix_valid && pix_ready;
                pv = pix_valid;
                pr = pix_ready;
                px = pix_x;
                py = pix_y;
                pc = pix_colour;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_clear_done"}, int'(clear_done), 0);
        check({tag, "_scan_done"}, int'(scan_done), 0);
        check({tag, "_pix_valid"}, int'(pix_valid), 0);
        check({tag, "_pix_x"}, int'(pix_x), 0);
        check({tag, "_pix_y"}, int'(pix_y), 0);
        check({tag, "_plot_count"}, int'(plot_count), 0);
    endtask

    task automatic do_clear(input logic [2:0] col, input bit with_scan,
                            input bit plot_mid, input int abort_at);
        int n;
        int busy_cycles;
        int pulses;
        clear_colour = col;
        clear_start  = 1'b1;
        scan_start   = with_scan;
        tick();
        clear_start = 1'b0;
        scan_start  = 1'b0;
        check("clear_busy_start", int'(busy), 1);
        n = 0;
        busy_cycles = 1;
        pulses = 0;
        while (n < N + 5) begin
            if (abort_at > 0 && n == abort_at) break;
            if (plot_mid && n == N / 2) begin
                vga_x = 8'd3; vga_y = 7'd3; vga_colour = 3'd7; vga_plot = 1'b1;
            end
            tick();
            n++;
            vga_plot = 1'b0;
            if (busy) busy_cycles++;
            if (clear_done) begin
                pulses++;
                if (pulses == 1) check("clear_done_cycle", n, N);
            end
        end
        model_count = 0;
        if (abort_at > 0) begin
            rst_n = 1'b0;
            tick();
            check_reset_outputs("abort");
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                tick();
                check("abort_no_done", int'(clear_done), 0);
                check("abort_idle", int'(busy), 0);
            end
            for (int i = 0; i < abort_at; i++) begin
                model_mem[i] = col;
                model_dc[i]  = 1'b0;
            end
            model_dc[abort_at] = 1'b1;
        end else begin
            check("clear_busy_cycles", busy_cycles, N);
            check("clear_done_pulses", pulses, 1);
            check("clear_idle_after", int'(busy), 0);
            check("clear_plot_count", int'(plot_count), model_count);
            for (int i = 0; i < N; i++) begin
                model_mem[i] = col;
                model_dc[i]  = 1'b0;
            end
        end
    endtask

    task automatic do_plot(input int x, input int y, input logic [2:0] c);
        vga_x = 8'(x);
        vga_y = 7'(y);
        vga_colour = c;
        vga_plot = 1'b1;
        tick();
        vga_plot = 1'b0;
        if (x < W && y < H) begin
            model_mem[y * W + x] = c;
            model_dc[y * W + x]  = 1'b0;
            if (model_count < 65535) model_count++;
        end
        check("plot_count", int'(plot_count), model_count);
    endtask

    // coll_at >= 0 plots colour 6 to that pixel in its FETCH cycle.
    task automatic do_scan(input bit rr, input int coll_at);
        int n;
        for (int i = 0; i < N; i++) begin
            exp_mem[i] = model_mem[i];
            exp_dc[i]  = model_dc[i];
        end
        scan_idx = 0;
        done_pulses = 0;
        rand_ready = rr;
        scanning = 1'b1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        n = 0;
        while (!scan_done && n < 8 * N) begin
            if (coll_at >= 0 && n == 2 * coll_at) begin
                vga_x = 8'(coll_at % W);
                vga_y = 7'(coll_at / W);
                vga_colour = 3'd6;
                vga_plot = 1'b1;
            end
            tick();
            n++;
            if (vga_plot) begin
                vga_plot = 1'b0;
                model_mem[coll_at] = 3'd6;
                if (model_count < 65535) model_count++;
            end
        end
        check("scan_no_timeout", int'(n < 8 * N), 1);
        if (!rr) check("scan_cycles", n, 2 * N);
        check("scan_handshakes", scan_idx, N);
        tick();
        scanning = 1'b0;
        rand_ready = 1'b0;
        check("scan_done_pulses", done_pulses, 1);
        check("scan_plot_count", int'(plot_count), model_count);
    endtask

    initial begin : stimulus
        int nz;
        for (int i = 0; i < N; i++) begin
            model_mem[i] = '0;
            model_dc[i]  = 1'b1;
            captured[i]  = '0;
        end

        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Clear to 2 and read every pixel back.
        do_clear(3'b010, 1'b0, 1'b0, 0);
        do_scan(1'b0, -1);
        check("scan_first_colour", int'(captured[0]), 2);
        check("scan_last_colour", int'(captured[N - 1]), 2);

        // Corner, centre and out-of-range plots.
        do_clear(3'b000, 1'b0, 1'b0, 0);
        do_plot(0, 0, 3'd7);
        do_plot(W - 1, H - 1, 3'd5);
        do_plot(W / 2, H / 2, 3'd3);
        do_plot(W, 10, 3'd1);
        do_plot(10, H, 3'd2);
        check("plot_count_literal", int'(plot_count), 3);
        do_scan(1'b0, -1);
        check("pix0_literal", int'(captured[0]), 7);
        check("pix130_literal", int'(captured[130]), 3);
        check("pix239_literal", int'(captured[239]), 5);
        nz = 0;
        for (int i = 0; i < N; i++) if (captured[i] != 3'd0) nz++;
        check("nonzero_pixels", nz, 3);

        // Backpressured readout of the same frame.
        do_scan(1'b1, -1);

        // Simultaneous starts: clear wins; mid-clear plot is dropped.
        do_clear(3'b001, 1'b1, 1'b1, 0);
        check("count_after_clear_literal", int'(plot_count), 0);

        // Plot colliding with the FETCH of pixel (5,0).
        do_scan(1'b0, 5);
        check("collision_old_literal", int'(captured[5]), 1);
        check("collision_count", int'(plot_count), 1);
        do_scan(1'b0, -1);
        check("collision_new_literal", int'(captured[5]), 6);

        // Reset partway through a clear to 4.
        do_clear(3'b100, 1'b0, 1'b0, 100);
        do_scan(1'b0, -1);
        check("abort_cleared_literal", int'(captured[50]), 4);
        check("abort_cleared5_literal", int'(captured[5]), 4);
        check("abort_kept_literal", int'(captured[150]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
